tdc_avg: RTL and testbench

TDC_AVG -- requirements
Module: tdc_avg

---
 rtl/tdc_pkg.sv | 14 +
 rtl/tdc_out_reg.sv | 93 +++++++++
 rtl/tdc_avg.sv | 127 ++++++++++++
 tb/tb_tdc_avg.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC batch averager.
// Width defaults, rejection-count width and output-state encoding.
package tdc_pkg;

  localparam int DW_DEF     = 20;
  localparam int LOG2_N_DEF = 4;
  localparam int REJ_W      = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_st_t;

endpackage

// File: rtl/tdc_out_reg.sv
// Output holding register for batch results.
// A one-deep EMPTY/FULL buffer with a sticky overflow flag.
module tdc_out_reg
  import tdc_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DW-1:0]    ld_data,
  input  logic [DW-1:0]    ld_min,
  input  logic [DW-1:0]    ld_max,
  input  logic [REJ_W-1:0] ld_rej,
  input  logic             o_ready,
  output logic [DW-1:0]    o_data,
  output logic [DW-1:0]    o_min,
  output logic [DW-1:0]    o_max,
  output logic [REJ_W-1:0] o_rej,
  output logic             o_dval,
  output logic             o_ovf
);

  out_st_t st;
  out_st_t nxt;
  logic    cap;
  logic    set_ovf;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st <= EMPTY;
    end else begin
      st <= nxt;
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      EMPTY: begin
        if (load) nxt = FULL;
      end
      FULL: begin
        if (!load && o_ready) nxt = EMPTY;
      end
      default: nxt = EMPTY;
    endcase
  end

  // A result arriving while the held one is unaccepted is dropped.
  always_comb begin
    cap     = 1'b0;
    set_ovf = 1'b0;
    o_dval  = 1'b0;
    unique case (st)
      EMPTY: begin
        cap = load;
      end
      FULL: begin
        o_dval  = 1'b1;
        cap     = load && o_ready;
        set_ovf = load && !o_ready;
      end
      default: begin
        cap = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
      o_min  <= '0;
      o_max  <= '0;
      o_rej  <= '0;
    end else if (cap && !clr) begin
      o_data <= ld_data;
      o_min  <= ld_min;
      o_max  <= ld_max;
      o_rej  <= ld_rej;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      o_ovf <= 1'b0;
    end else if (set_ovf) begin
      o_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/tdc_avg.sv
// Windowed batch averager for TDC difference samples.
// Emits rounded mean, min, max and reject count per 2^LOG2_N samples.
module tdc_avg
  import tdc_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dval,
  input  logic [DW-1:0]    i_data,
  input  logic [DW-1:0]    win_lo,
  input  logic [DW-1:0]    win_hi,
  input  logic             clr,
  output logic [DW-1:0]    o_data,
  output logic [DW-1:0]    o_min,
  output logic [DW-1:0]    o_max,
  output logic [REJ_W-1:0] o_rej,
  output logic             o_dval,
  input  logic             o_ready,
  output logic             o_ovf
);

  localparam int AW = DW + LOG2_N;
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int N  = 1 << LOG2_N;
  localparam logic [AW-1:0] HALF = AW'((1 << LOG2_N) >> 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [REJ_W-1:0] RMAX = '1;

  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    mn;
  logic [DW-1:0]    mx;
  logic [REJ_W-1:0] rej;

  logic             in_win;
  logic             take;
  logic             drop;
  logic             last;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    rsum;
  logic [DW-1:0]    avg;
  logic [DW-1:0]    nmn;
  logic [DW-1:0]    nmx;

  logic             pend;
  logic [DW-1:0]    p_data;
  logic [DW-1:0]    p_min;
  logic [DW-1:0]    p_max;
  logic [REJ_W-1:0] p_rej;

  assign in_win = (i_data >= win_lo) && (i_data <= win_hi);
  assign take   = i_dval && in_win && !clr;
  assign drop   = i_dval && !in_win && !clr;
  assign last   = take && (cnt == LAST);

  // N*(2^DW-1) + N/2 still fits in AW bits, so no wrap.
  assign sum  = acc + AW'(i_data);
  assign rsum = sum + HALF;
  assign avg  = rsum[AW-1:LOG2_N];
  assign nmn  = (i_data < mn) ? i_data : mn;
  assign nmx  = (i_data > mx) ? i_data : mx;

  always_ff @(posedge clk) begin
    if (rst || clr || last) begin
      acc <= '0;
      cnt <= '0;
      mn  <= '1;
      mx  <= '0;
      rej <= '0;
    end else begin
      if (take) begin
        acc <= sum;
        cnt <= cnt + CW'(1);
        mn  <= nmn;
        mx  <= nmx;
      end
      if (drop && rej != RMAX) begin
        rej <= rej + REJ_W'(1);
      end
    end
  end

  // Result staging: handed to the output buffer one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      p_data <= '0;
      p_min  <= '0;
      p_max  <= '0;
      p_rej  <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else begin
      pend <= last;
      if (last) begin
        p_data <= avg;
        p_min  <= nmn;
        p_max  <= nmx;
        p_rej  <= rej;
      end
    end
  end

  tdc_out_reg #(
    .DW(DW)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load    (pend),
    .ld_data (p_data),
    .ld_min  (p_min),
    .ld_max  (p_max),
    .ld_rej  (p_rej),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_min   (o_min),
    .o_max   (o_max),
    .o_rej   (o_rej),
    .o_dval  (o_dval),
    .o_ovf   (o_ovf)
  );

endmodule

// File: tb/tb_tdc_avg.sv
// Bench for tdc_avg: table vectors, corner sequences,
// and random traffic against a queue-based reference model.
module tb_tdc_avg;

  localparam int DW = 20;
  localparam int LG = 4;
  localparam int N  = 16;
  localparam logic [DW-1:0] DMAX = 20'hFFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_dval;
  logic [DW-1:0] i_data;
  logic [DW-1:0] win_lo;
  logic [DW-1:0] win_hi;
  logic          clr;
  logic [DW-1:0] o_data;
  logic [DW-1:0] o_min;
  logic [DW-1:0] o_max;
  logic [7:0]    o_rej;
  logic          o_dval;
  logic          o_ready;
  logic          o_ovf;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  tdc_avg #(
    .DW(DW),
    .LOG2_N(LG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_dval  (i_dval),
    .i_data  (i_data),
    .win_lo  (win_lo),
    .win_hi  (win_hi),
    .clr     (clr),
    .o_data  (o_data),
    .o_min   (o_min),
    .o_max   (o_max),
    .o_rej   (o_rej),
    .o_dval  (o_dval),
    .o_ready (o_ready),
    .o_ovf   (o_ovf)
  );

  typedef struct {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    bit            alt;
    logic [DW-1:0] s0;
    logic [DW-1:0] s1;
    int            ns;
    logic [DW-1:0] ed;
    logic [DW-1:0] emn;
    logic [DW-1:0] emx;
    logic [7:0]    erj;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    i_dval = 1'b1;
    i_data = d;
    tick();
    i_dval = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_res(input string nm,
                         input logic [DW-1:0] d,
                         input logic [DW-1:0] mn,
                         input logic [DW-1:0] mx,
                         input logic [7:0] rj);
    chk({nm, ".dval"}, 32'(o_dval), 32'd1);
    chk({nm, ".data"}, 32'(o_data), 32'(d));
    chk({nm, ".min"}, 32'(o_min), 32'(mn));
    chk({nm, ".max"}, 32'(o_max), 32'(mx));
    chk({nm, ".rej"}, 32'(o_rej), 32'(rj));
  endtask

  // Reference model: queue of accepted samples per batch,
  // a one-result staging slot and a one-deep output buffer.
  int unsigned   q[$];
  int            mrej;
  bit            mpend;
  logic [DW-1:0] pd, pmn, pmx;
  logic [7:0]    prj;
  bit            hv, movf;
  logic [DW-1:0] hd, hmn, hmx;
  logic [7:0]    hrj;

  task automatic m_edge(input bit r, input bit c,
                        input bit dv,
                        input logic [DW-1:0] d,
                        input logic [DW-1:0] lo,
                        input logic [DW-1:0] hi,
                        input bit rdy);
    longint s;
    int unsigned a, b;
    if (r) begin
      q.delete();
      mrej = 0; mpend = 0;
      hv = 0; movf = 0;
      hd = '0; hmn = '0; hmx = '0; hrj = '0;
    end else if (c) begin
      q.delete();
      mrej = 0; mpend = 0;
      hv = 0; movf = 0;
    end else begin
      if (mpend) begin
        if (!hv || rdy) begin
          hv = 1;
          hd = pd; hmn = pmn; hmx = pmx; hrj = prj;
        end else begin
          movf = 1;
        end
      end else if (hv && rdy) begin
        hv = 0;
      end
      mpend = 0;
      if (dv) begin
        if (d >= lo && d <= hi) begin
          q.push_back(int'(d));
          if (q.size() == N) begin
            s = 0; a = q[0]; b = q[0];
            foreach (q[k]) begin
              s += q[k];
              if (q[k] < a) a = q[k];
              if (q[k] > b) b = q[k];
            end
            pd = DW'((s + N / 2) / N);
            pmn = DW'(a); pmx = DW'(b);
            prj = 8'(mrej);
            mrej = 0;
            q.delete();
            mpend = 1;
          end
        end else if (mrej < 255) begin
          mrej++;
        end
      end
    end
  endtask

  task automatic mtick();
    bit r, c, dv, rdy;
    logic [DW-1:0] d, lo, hi;
    r = rst; c = clr; dv = i_dval; rdy = o_ready;
    d = i_data; lo = win_lo; hi = win_hi;
    @(posedge clk);
    m_edge(r, c, dv, d, lo, hi, rdy);
    #1;
    chk("rnd.dval", 32'(o_dval), 32'(hv));
    chk("rnd.ovf", 32'(o_ovf), 32'(movf));
    if (hv) begin
      chk("rnd.data", 32'(o_data), 32'(hd));
      chk("rnd.min", 32'(o_min), 32'(hmn));
      chk("rnd.max", 32'(o_max), 32'(hmx));
      chk("rnd.rej", 32'(o_rej), 32'(hrj));
    end
  endtask

  task automatic new_window();
    int unsigned t;
    logic [DW-1:0] lo;
    case ($urandom_range(0, 3))
      0: begin
        win_lo = '0;
        win_hi = DMAX;
      end
      1: begin
        lo = DW'($urandom_range(0, 20'hFFFFF));
        t = int'(lo) + $urandom_range(0, 4000);
        if (t > 20'hFFFFF) t = 20'hFFFFF;
        win_lo = lo;
        win_hi = DW'(t);
      end
      2: begin
        win_hi = DW'($urandom_range(0, 1000));
        win_lo = win_hi + DW'($urandom_range(1, 50));
      end
      default: begin
        win_lo = DW'($urandom_range(0, 20));
        win_hi = win_lo + DW'($urandom_range(0, 30));
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    i_dval = 1'b0; i_data = '0;
    win_lo = '0; win_hi = DMAX;
    o_ready = 1'b1;

    tbl[0] = '{'0, DMAX, 0, 20'd100, 20'd0, 16,
               20'd100, 20'd100, 20'd100, 8'd0};
    tbl[1] = '{'0, DMAX, 0, 20'd0, 20'd1, 16,
               20'd8, 20'd0, 20'd15, 8'd0};
    tbl[2] = '{20'd50, 20'd60, 1, 20'd40, 20'd55, 32,
               20'd55, 20'd55, 20'd55, 8'd16};
    tbl[3] = '{'0, DMAX, 0, DMAX, 20'd0, 16,
               DMAX, DMAX, DMAX, 8'd0};
    tbl[4] = '{'0, DMAX, 0, 20'd1, 20'd1, 16,
               20'd9, 20'd1, 20'd16, 8'd0};
    tbl[5] = '{20'd10, 20'd20, 1, 20'd9, 20'd10, 32,
               20'd10, 20'd10, 20'd10, 8'd16};
    tbl[6] = '{20'd10, 20'd20, 1, 20'd21, 20'd20, 32,
               20'd20, 20'd20, 20'd20, 8'd16};

    tick(); tick();
    rst = 1'b0;
    chk("rst.data", 32'(o_data), 32'd0);
    chk("rst.min", 32'(o_min), 32'd0);
    chk("rst.max", 32'(o_max), 32'd0);
    chk("rst.rej", 32'(o_rej), 32'd0);
    chk("rst.dval", 32'(o_dval), 32'd0);
    chk("rst.ovf", 32'(o_ovf), 32'd0);

    foreach (tbl[v]) begin
      win_lo = tbl[v].lo;
      win_hi = tbl[v].hi;
      o_ready = 1'b1;
      do_clr();
      for (int k = 0; k < tbl[v].ns; k++) begin
        if (tbl[v].alt)
          send((k % 2 == 0) ? tbl[v].s0 : tbl[v].s1);
        else
          send(tbl[v].s0 + DW'(k) * tbl[v].s1);
      end
      chk($sformatf("tbl%0d.lat", v), 32'(o_dval), 32'd0);
      tick();
      chk_res($sformatf("tbl%0d", v), tbl[v].ed,
              tbl[v].emn, tbl[v].emx, tbl[v].erj);
      tick();
      chk($sformatf("tbl%0d.drain", v),
          32'(o_dval), 32'd0);
    end

    // Overflow while the consumer stalls
    win_lo = '0; win_hi = DMAX;
    o_ready = 1'b0;
    do_clr();
    for (int k = 0; k < N; k++) send(20'd7);
    tick();
    chk_res("ovf.first", 20'd7, 20'd7, 20'd7, 8'd0);
    for (int k = 0; k < N; k++) send(20'd9);
    tick(); tick();
    chk_res("ovf.held", 20'd7, 20'd7, 20'd7, 8'd0);
    chk("ovf.set", 32'(o_ovf), 32'd1);
    o_ready = 1'b1;
    tick();
    chk("ovf.acc.dval", 32'(o_dval), 32'd0);
    chk("ovf.sticky", 32'(o_ovf), 32'd1);
    tick();
    chk("ovf.sticky2", 32'(o_ovf), 32'd1);
    do_clr();
    chk("ovf.clr", 32'(o_ovf), 32'd0);

    // Reset mid-batch, then clr racing a sample
    for (int k = 0; k < 7; k++) send(20'd1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.dval", 32'(o_dval), 32'd0);
    chk("mrst.data", 32'(o_data), 32'd0);
    for (int k = 0; k < N; k++) send(20'd5);
    tick();
    chk_res("mrst", 20'd5, 20'd5, 20'd5, 8'd0);
    tick();
    for (int k = 0; k < N - 1; k++) send(20'd5);
    clr = 1'b1;
    send(20'd1000);
    clr = 1'b0;
    chk("clrdv.dval", 32'(o_dval), 32'd0);
    for (int k = 0; k < N - 1; k++) send(20'd5);
    tick();
    chk("clrdv.part", 32'(o_dval), 32'd0);
    send(20'd5);
    tick();
    chk_res("clrdv", 20'd5, 20'd5, 20'd5, 8'd0);
    tick();

    // Reject counter saturation
    win_lo = 20'd10; win_hi = 20'd10;
    do_clr();
    for (int k = 0; k < 300; k++) send(20'd0);
    for (int k = 0; k < N; k++) send(20'd10);
    tick();
    chk_res("sat", 20'd10, 20'd10, 20'd10, 8'd255);
    tick();

    // Inverted window never yields a result
    win_lo = 20'd100; win_hi = 20'd50;
    do_clr();
    for (int k = 0; k < 40; k++) begin
      send((k % 2 == 0) ? 20'd75 : 20'd100);
    end
    tick(); tick();
    chk("inv.dval", 32'(o_dval), 32'd0);

    // Random traffic against the model
    rst = 1'b1;
    mtick();
    rst = 1'b0;
    for (int p = 0; p < 6; p++) begin
      new_window();
      clr = 1'b1;
      mtick();
      clr = 1'b0;
      for (int c = 0; c < 500; c++) begin
        i_dval = ($urandom_range(0, 9) < 7);
        if (win_lo <= win_hi &&
            $urandom_range(0, 3) != 0)
          i_data = win_lo +
            DW'($urandom_range(0, int'(win_hi - win_lo)));
        else
          i_data = DW'($urandom_range(0, 20'hFFFFF));
        o_ready = (p % 2 == 0) ? 1'b1 :
                  1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 199) == 0);
        mtick();
      end
      i_dval = 1'b0;
      clr = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
